// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer: wide add/sub, one 5-bit lookahead slice per clock with a registered carry chain
module cla_chunk_sequencer #(
    parameter int CHUNKS = 4,
    localparam int W = 5 * CHUNKS,
    localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [4:0] g, p;
    logic [5:0] c;
    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    // lookahead carries for the slice selected by idx
    always_comb begin
        g = a_q[5*idx_q +: 5] & b_q[5*idx_q +: 5];
        p = a_q[5*idx_q +: 5] ^ b_q[5*idx_q +: 5];
        c[0] = c_q;
        c[1] = g[0] | p[0] & c[0];
        c[2] = g[1] | p[1] & g[0] | (&p[1:0]) & c[0];
        c[3] = g[2] | p[2] & g[1] | (&p[2:1]) & g[0] | (&p[2:0]) & c[0];
        c[4] = g[3] | p[3] & g[2] | (&p[3:2]) & g[1] | (&p[3:1]) & g[0] | (&p[3:0]) & c[0];
        c[5] = g[4] | p[4] & g[3] | (&p[4:3]) & g[2] | (&p[4:2]) & g[1] | (&p[4:1]) & g[0]
             | (&p[4:0]) & c[0];
    end
    // next state: accept in IDLE/DONE, process one slice per RUN cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == RUN) begin
            sum_d[5*idx_q +: 5] = p ^ c[4:0];
            c_d   = c[5];
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(CHUNKS - 1)) begin
                state_d = DONE;
                idx_d   = '0;
                cout_d  = c[5];
                ovf_d   = c[4] ^ c[5];
            end
        end else begin
            state_d = start ? RUN : IDLE;
            if (start) begin
                idx_d = '0;
                a_d   = a;
                b_d   = sub ? ~b : b;
                c_d   = sub ? 1'b1 : cin;
            end
        end
    end
    // state registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// tb_cla_chunk_sequencer: table vectors, corner sequences and random back-to-back ops vs an arithmetic model
module tb_cla_chunk_sequencer;
    localparam int CHUNKS = 4;
    localparam int W = 5 * CHUNKS;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, cout, ovf;
    logic [W-1:0] sum;
    int passed = 0, total = 0;

    cla_chunk_sequencer #(.CHUNKS(CHUNKS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic s;
        logic [W-1:0] x, y;
        logic ci;
        logic [W-1:0] r;
        logic rc, ro;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] full;
        logic [W-1:0] r;
        logic rc, ro;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            r = full[W-1:0];
            rc = full[W];
            ro = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            r = x - y;
            rc = x >= y;
            ro = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {ro, rc, r};
    endfunction

    task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         output int nbusy, output int overlap);
        int n;
        sub = s; a = x; b = y; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
        nbusy = 0; overlap = 0; n = 0;
        while (!done && n < 100) begin
            if (busy) nbusy++;
            tick();
            n++;
        end
        if (busy && done) overlap++;
        if (!done) begin
            total++;
            $display("FAIL op_timeout: no done after %0d cycles, expected done", n);
        end
    endtask

    initial begin
        vec_t vt[5];
        int nb, ov, ndone, last, cyc;
        logic [W+1:0] m;
        logic ps;
        logic [W-1:0] px, py;
        logic pc;

        vt[0] = '{1'b0, 20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0};
        vt[1] = '{1'b0, 20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1};
        vt[2] = '{1'b0, 20'h12345, 20'h0ABCD, 1'b1, 20'h1CF13, 1'b0, 1'b0};
        vt[3] = '{1'b1, 20'h00005, 20'h00007, 1'b1, 20'hFFFFE, 1'b0, 1'b0};
        vt[4] = '{1'b1, 20'h80000, 20'h00001, 1'b0, 20'h7FFFF, 1'b1, 1'b1};

        tick(); tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_ovf", ovf, 0);

        for (int i = 0; i < 5; i++) begin
            do_op(vt[i].s, vt[i].x, vt[i].y, vt[i].ci, nb, ov);
            check($sformatf("vec%0d_busy_cycles", i), nb, CHUNKS);
            check($sformatf("vec%0d_overlap", i), ov, 0);
            check($sformatf("vec%0d_sum", i), sum, vt[i].r);
            check($sformatf("vec%0d_cout", i), cout, vt[i].rc);
            check($sformatf("vec%0d_ovf", i), ovf, vt[i].ro);
            tick();
            check($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // start re-pulsed with other operands during RUN cycles 2 and 3
        sub = 1'b0; a = 20'h11111; b = 20'h22222; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 20'hFFFFF; b = 20'hFFFFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                check("ignore_sum", sum, 20'h33333);
                check("ignore_cout", cout, 0);
            end
            tick();
        end
        check("ignore_done_count", ndone, 1);

        // reset during the second RUN cycle
        sub = 1'b0; a = 20'h0F0F0; b = 20'h01234; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            tick();
        end
        check("abort_no_done", ndone, 0);
        do_op(1'b0, 20'h0F0F0, 20'h01234, 1'b1, nb, ov);
        m = model(1'b0, 20'h0F0F0, 20'h01234, 1'b1);
        check("after_abort_sum", sum, m[W-1:0]);
        check("after_abort_busy", nb, CHUNKS);

        // start held high, new random operands on each done
        ps = 1'($urandom); px = W'($urandom); py = W'($urandom); pc = 1'($urandom);
        sub = ps; a = px; b = py; cin = pc; start = 1'b1;
        tick();
        ndone = 0; last = -1; cyc = 0;
        while (ndone < 10000 && cyc < 60000) begin
            if (busy && done) check("b2b_overlap", 1, 0);
            if (done) begin
                m = model(ps, px, py, pc);
                check("b2b_sum", sum, m[W-1:0]);
                check("b2b_cout", cout, m[W]);
                check("b2b_ovf", ovf, m[W+1]);
                if (last >= 0) check("b2b_interval", cyc - last, CHUNKS + 1);
                last = cyc;
                ndone++;
                ps = 1'($urandom); pc = 1'($urandom);
                px = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
                py = ($urandom_range(0, 7) == 0) ? W'(1) : W'($urandom);
                sub = ps; a = px; b = py; cin = pc;
            end else if (busy) begin
                a = W'($urandom); b = W'($urandom);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("b2b_op_count", ndone, 10000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cla_chunk_sequencer.md
# cla_chunk_sequencer

Multi-cycle wide adder/subtractor that adds two operands of 5*CHUNKS bits in 5-bit slices, one slice per clock, reusing one 5-bit generate/propagate carry-lookahead stage. The carry out of each slice is registered and chained into the next. It sits between a requester (a start/done handshake) and the shared lookahead datapath. It trades latency for area on wide words.

## Interface
- CHUNKS, 4: number of 5-bit slices. Operand width W = 5*CHUNKS. Legal range 1..16.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only when the block is not busy.
- sub  input  1  0 = A+B+cin; 1 = A−B (B inverted, carry-in forced to 1, cin ignored). Latched on accepted start.
- a  input  W  operand A. Latched on accepted start.
- b  input  W  operand B. Latched on accepted start.
- cin  input  1  carry-in for add mode. Latched on accepted start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid.
- sum  output  W  result. Held until overwritten by the next completed operation.
- cout  output  1  carry out of bit W−1. In subtract mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into bit W−1 XOR carry out of bit W−1.

## Operation
- FSM states:
  - IDLE: busy=0. start=1 → RUN, with idx=0, registers A/B'/carry loaded.
  - RUN: busy=1. One slice per cycle. When idx=CHUNKS−1 → DONE, otherwise idx+1.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 → RUN (back-to-back), otherwise → IDLE.
- On accept: B' = sub ? ~b : b; carry register = sub ? 1 : cin. Any previous sum/cout/ovf values are left untouched until the new operation writes them.
- Per RUN cycle for slice idx (bits 5*idx+4 : 5*idx):
  - G = A & B', P = A ^ B'. c0 = carry register.
  - c1 = G0|P0c0
  - c2 = G1|P1G0|P1P0c0
  - c3 = G2|P2G1|P2P1G0|P2P1P0c0
  - c4 = G3|P3G2|P3P2G1|P3P2P1G0|P3P2P1P0c0
  - c5 = G4|P4G3|P4P3G2|P4P3P2G1|P4P3P2P1G0|P4P3P2P1P0c0 (all terms present)
  - Slice sum = P ^ {c4..c0}, written into the sum register at the slice position. Carry register ← c5.
- On the last slice: cout ← c5; ovf ← c4 ^ c5.
- Sum slices may be written in place during RUN. Consumers sample sum only on done.
- start while in RUN is ignored: no queueing, and operands are not re-latched.
- Width rules: idx is ceil(log2(CHUNKS)) bits, minimum 1. No wrap beyond CHUNKS−1. All arithmetic is modulo 2^W plus cout.

## Timing
- Reset (rst=1 at an edge): state IDLE, idx=0, busy=0, done=0, sum=0, cout=0, ovf=0, carry register=0.
- Reset has priority over start and aborts any RUN. No done is produced for an aborted operation.
- Latency: start accepted at edge k.
  - busy is high from after edge k until edge k+CHUNKS.
  - Slices are processed at edges k+1 … k+CHUNKS.
  - done, sum, cout and ovf are valid in the cycle after edge k+CHUNKS. That is CHUNKS+1 edges from accept to done.
- Throughput: start asserted in the DONE cycle is accepted. One result every CHUNKS+1 cycles.
- done and busy are never high together.
- CHUNKS=1: RUN lasts one cycle; done follows the next edge.

## Test plan
- CHUNKS=4, add, a=0xFFFFF, b=0x00001, cin=0 → 4 busy cycles, then done with sum=0x00000, cout=1, ovf=0.
- add, a=0x7FFFF, b=0x00001, cin=0 → sum=0x80000, cout=0, ovf=1. Then a=0x12345, b=0x0ABCD, cin=1 → sum=0x1CF13, cout=0, ovf=0.
- sub, a=0x00005, b=0x00007 → sum=0xFFFFE, cout=0, ovf=0. Then sub, a=0x80000, b=0x00001 → sum=0x7FFFF, cout=1, ovf=1.
- start pulsed again with different operands during RUN cycles 2 and 3 → ignored; the result matches the first operands; done pulses exactly once.
- rst asserted during the second RUN cycle → next cycle busy=0, done=0, sum=0, cout=0; no done follows; a fresh start then completes normally.
- start held high continuously with a new operand pair each accept → a done pulse every 5 cycles, each result correct; exhaustive random compare against A+B+cin (or A−B) over 10,000 operations.
